arith_port_sequencer: RTL and testbench

Control engine on the arithmetic side of the shared dual-port operand RAM. The HPS loads operand vectors A and B through the RAM's HPS port, then programs this block over its own Avalon-MM CSR slave and starts it. The block walks the RAM's arithmetic port: it reads A[i] and B[i], forms the 32-bit sum, and writes R[i] back, so the HPS can read the results from the same RAM. It is instantiated beside the RAM wrapper and drives that wrapper's addr_arith/data_arith/we_arith inputs and consumes its q_arith output.

---
 rtl/arith_port_sequencer.sv | 150 +++++++++++++++
 tb/tb_arith_port_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_port_sequencer.sv
// Walks the arithmetic port of the shared operand RAM, writing R[i] = A[i] + B[i]
// for a CSR-programmed vector length, with sticky carry reporting.
module arith_port_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  read,
    input  logic                  write,
    input  logic [2:0]            address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [ADDR_WIDTH-1:0] addr_arith,
    output logic [DATA_WIDTH-1:0] data_arith,
    output logic                  we_arith,
    input  logic [DATA_WIDTH-1:0] q_arith
);

    typedef enum logic [2:0] {IDLE, LD_A, LD_B, ADD, WR, FIN} state_t;

    state_t                state;
    logic [1:0]            ctrl_reg;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   index;
    logic [ADDR_WIDTH:0]   next_index;
    logic                  busy;
    logic                  done;
    logic                  carry;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH:0]   sum;
    logic [31:0]           rd_mux;
    logic                  start_req;
    logic                  clear_req;
    logic                  unused_bits;

    assign next_index  = index + 1'b1;
    assign sum         = {1'b0, op_a} + {1'b0, q_arith};
    assign start_req   = write && (address == 3'd0) && writedata[0];
    assign clear_req   = write && (address == 3'd0) && writedata[1];
    assign unused_bits = ^writedata[31:ADDR_WIDTH+1];

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = {30'd0, ctrl_reg};
            3'd1: rd_mux = 32'(base_a);
            3'd2: rd_mux = 32'(base_b);
            3'd3: rd_mux = 32'(base_r);
            3'd4: rd_mux = 32'(count);
            3'd5: rd_mux = {29'd0, carry, done, busy};
            3'd6: rd_mux = 32'(index);
            3'd7: rd_mux = 32'h4144_4431;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            readdata   <= '0;
            addr_arith <= '0;
            data_arith <= '0;
            we_arith   <= 1'b0;
            ctrl_reg   <= '0;
            base_a     <= '0;
            base_b     <= '0;
            base_r     <= '0;
            count      <= '0;
            index      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            carry      <= 1'b0;
            op_a       <= '0;
        end else begin
            if (read)
                readdata <= rd_mux;

            // Operand setup registers are frozen for the duration of a run.
            if (write) begin
                case (address)
                    3'd0: ctrl_reg <= writedata[1:0];
                    3'd1: if (!busy) base_a <= writedata[ADDR_WIDTH-1:0];
                    3'd2: if (!busy) base_b <= writedata[ADDR_WIDTH-1:0];
                    3'd3: if (!busy) base_r <= writedata[ADDR_WIDTH-1:0];
                    3'd4: if (!busy) count  <= writedata[ADDR_WIDTH:0];
                    default: ;
                endcase
            end

            if (clear_req) begin
                done  <= 1'b0;
                carry <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        index <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        if (count == '0) begin
                            state <= FIN;
                        end else begin
                            state      <= LD_A;
                            addr_arith <= base_a;
                        end
                    end
                end
                LD_A: begin
                    addr_arith <= base_b + index[ADDR_WIDTH-1:0];
                    state      <= LD_B;
                end
                LD_B: begin
                    op_a  <= q_arith;
                    state <= ADD;
                end
                // q_arith now carries the B word; the write is staged for WR.
                ADD: begin
                    data_arith <= sum[DATA_WIDTH-1:0];
                    if (sum[DATA_WIDTH])
                        carry <= 1'b1;
                    addr_arith <= base_r + index[ADDR_WIDTH-1:0];
                    we_arith   <= 1'b1;
                    state      <= WR;
                end
                WR: begin
                    we_arith <= 1'b0;
                    index    <= next_index;
                    if (next_index == count) begin
                        state <= FIN;
                    end else begin
                        addr_arith <= base_a + next_index[ADDR_WIDTH-1:0];
                        state      <= LD_A;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_port_sequencer.sv
// Randomized bench for arith_port_sequencer with a behavioural RAM and a
// vector-level reference model of the add-and-write-back sequence.
module tb_arith_port_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [10:0] addr_arith;
    logic [31:0] data_arith;
    logic        we_arith;
    logic [31:0] q_arith;

    always #5 clock = ~clock;

    arith_port_sequencer #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .addr_arith (addr_arith),
        .data_arith (data_arith),
        .we_arith   (we_arith),
        .q_arith    (q_arith)
    );

    // Operand RAM port B plus a host loading port standing in for the HPS side.
    logic [31:0] mem [2048];
    logic        hostWe;
    logic [10:0] hostAddr;
    logic [31:0] hostData;

    always @(posedge clock) begin
        if (we_arith)
            mem[addr_arith] <= data_arith;
        else if (hostWe)
            mem[hostAddr] <= hostData;
        q_arith <= mem[addr_arith];
    end

    int cyc = 0;
    int weCount = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (we_arith)
            weCount <= weCount + 1;
    end

    logic [31:0] refMem [2048];
    logic        refCarry;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic csrWrite(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    task automatic csrRead(input logic [2:0] a, output logic [31:0] d);
        read = 1'b1;
        address = a;
        @(posedge clock);
        #1;
        read = 1'b0;
        d = readdata;
    endtask

    task automatic ramPoke(input int a, input logic [31:0] d);
        hostWe = 1'b1;
        hostAddr = 11'(a);
        hostData = d;
        @(posedge clock);
        #1;
        hostWe = 1'b0;
        refMem[a] = d;
    endtask

    // Element-by-element semantics: each element reads both operands after all
    // earlier results have landed, so overlapping regions fall out naturally.
    task automatic modelRun(input int ba, input int bb, input int br, input int n);
        logic [32:0] s;
        for (int i = 0; i < n; i++) begin
            s = {1'b0, refMem[(ba + i) % 2048]} + {1'b0, refMem[(bb + i) % 2048]};
            refMem[(br + i) % 2048] = s[31:0];
            if (s[32])
                refCarry = 1'b1;
        end
    endtask

    task automatic memDiffCheck(input string name);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 2048; i++)
            if (mem[i] !== refMem[i])
                diffs++;
        checkOutput({name, "_mem_diffs"}, 32'(diffs), 32'd0);
    endtask

    task automatic startAndWait(input logic [31:0] ctrl, input int n, input bit pokeBusy, output int elapsed);
        int startCyc;
        csrWrite(3'd0, ctrl);
        startCyc = cyc;
        if (pokeBusy) begin
            csrWrite(3'd1, 32'h555);
            csrWrite(3'd0, 32'd1);
            csrWrite(3'd4, 32'd7);
        end
        elapsed = -1;
        read = 1'b1;
        address = 3'd5;
        for (int k = 0; k < 4 * n + 50; k++) begin
            @(posedge clock);
            #1;
            if (readdata[1]) begin
                elapsed = cyc - startCyc;
                break;
            end
        end
        read = 1'b0;
    endtask

    task automatic applyStimulus(input int ba, input int bb, input int br, input int n,
                                 input logic [31:0] ctrl, input bit pokeBusy, input string name);
        int          w0;
        int          elapsed;
        logic [31:0] d;
        csrWrite(3'd1, 32'(ba));
        csrWrite(3'd2, 32'(bb));
        csrWrite(3'd3, 32'(br));
        csrWrite(3'd4, 32'(n));
        if (ctrl[1])
            refCarry = 1'b0;
        modelRun(ba, bb, br, n);
        w0 = weCount;
        startAndWait(ctrl, n, pokeBusy, elapsed);
        checkOutput({name, "_done_cycles"}, 32'(elapsed), 32'(4 * n + 2));
        checkOutput({name, "_we_pulses"}, 32'(weCount - w0), 32'(n));
        csrRead(3'd5, d);
        checkOutput({name, "_status"}, d, {29'd0, refCarry, 2'b10});
        csrRead(3'd6, d);
        checkOutput({name, "_index"}, d, 32'(n));
        if (pokeBusy) begin
            csrRead(3'd1, d);
            checkOutput({name, "_base_a_kept"}, d, 32'(ba));
            csrRead(3'd4, d);
            checkOutput({name, "_count_kept"}, d, 32'(n));
        end
        for (int i = 0; i < n; i++)
            checkOutput({name, "_result"}, mem[(br + i) % 2048], refMem[(br + i) % 2048]);
        memDiffCheck(name);
    endtask

    initial begin
        logic [31:0] d;
        int          startCyc;
        int          w0;

        resetn = 1'b0;
        read = 1'b0;
        write = 1'b0;
        address = 3'd0;
        writedata = 32'd0;
        hostWe = 1'b0;
        hostAddr = 11'd0;
        hostData = 32'd0;
        refCarry = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_we", {31'd0, we_arith}, 32'd0);
        checkOutput("rst_addr", 32'(addr_arith), 32'd0);
        checkOutput("rst_data", data_arith, 32'd0);
        checkOutput("rst_readdata", readdata, 32'd0);
        resetn = 1'b1;

        csrRead(3'd5, d);
        checkOutput("rst_status", d, 32'd0);
        csrRead(3'd7, d);
        checkOutput("id", d, 32'h4144_4431);
        for (int a = 1; a <= 4; a++) begin
            csrRead(3'(a), d);
            checkOutput("rst_csr", d, 32'd0);
        end
        csrRead(3'd6, d);
        checkOutput("rst_index", d, 32'd0);

        for (int i = 0; i < 2048; i++)
            ramPoke(i, $urandom);

        for (int i = 0; i < 4; i++) begin
            ramPoke(i, 32'(i + 1));
            ramPoke(32'h100 + i, 32'(10 * (i + 1)));
        end
        applyStimulus(0, 32'h100, 32'h200, 4, 32'd3, 1'b0, "basic");
        for (int i = 0; i < 4; i++)
            checkOutput("basic_sum", mem[32'h200 + i], 32'(11 * (i + 1)));

        ramPoke(32'h7FF, 32'hFFFF_FFFF);
        ramPoke(32'h100, 32'd2);
        applyStimulus(32'h7FF, 32'h100, 32'h200, 2, 32'd3, 1'b0, "wrap");
        checkOutput("wrap_r0", mem[32'h200], 32'd1);

        applyStimulus(0, 32'h300, 0, 3, 32'd3, 1'b1, "inplace");

        for (int k = 0; k < 4; k++)
            applyStimulus($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                          $urandom_range(1, 24), (k % 2 == 1) ? 32'd3 : 32'd1, 1'b0, "rand");

        applyStimulus(5, 6, 7, 0, 32'd1, 1'b0, "zero");

        applyStimulus(0, 32'h400, 0, 2048, 32'd3, 1'b0, "full");

        // Abort element 1 during its ADD cycle; only element 0 may reach RAM.
        csrWrite(3'd1, 32'h10);
        csrWrite(3'd2, 32'h20);
        csrWrite(3'd3, 32'h30);
        csrWrite(3'd4, 32'd3);
        modelRun(32'h10, 32'h20, 32'h30, 1);
        csrWrite(3'd0, 32'd1);
        startCyc = cyc;
        while (cyc - startCyc < 6)
            begin @(posedge clock); #1; end
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        refCarry = 1'b0;
        w0 = weCount;
        checkOutput("abort_we_now", {31'd0, we_arith}, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("abort_we_pulses", 32'(weCount - w0), 32'd0);
        csrRead(3'd5, d);
        checkOutput("abort_status", d, 32'd0);
        csrRead(3'd1, d);
        checkOutput("abort_base_a", d, 32'd0);
        memDiffCheck("abort");
        applyStimulus(32'h10, 32'h20, 32'h30, 3, 32'd1, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
